// File: rtl/tlul_pkg.sv
// Shared TL-UL channel types used by the host and device adapters.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_responder_pkg.sv
// Local types and helpers for the TL-UL to SRAM responder.
package tlul_sram_responder_pkg;
    import tlul_pkg::*;

    // Per-request bookkeeping carried from A-channel accept to D-channel reply.
    typedef struct packed {
        tl_a_op_e   opcode;
        logic [1:0] size;
        logic [7:0] source;
        logic       req_err;
    } meta_t;

    localparam int MetaW = $bits(meta_t);
    localparam int RspW  = 33;  // {rdata, rerror}

    // Byte lanes a request of this size/offset is allowed to touch.
    function automatic logic [3:0] lane_mask(input logic [1:0] addr, input logic [1:0] size);
        case (size)
            2'd0:    lane_mask = 4'b0001 << addr;
            2'd1:    lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Widen each byte-enable bit into a full byte of bit mask.
    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/tlul_fifo_sync.sv
// Small synchronous FIFO; with Pass=1 an empty FIFO forwards its write port
// straight to the read port in the same cycle.
module tlul_fifo_sync #(
    parameter int Width = 8,
    parameter int Depth = 2,
    parameter bit Pass  = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wvalid_i,
    input  logic [Width-1:0]           wdata_i,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push, pop, bypass;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o  = (cnt_q == '0);
    assign full_o   = (cnt_q == CntW'(Depth));
    assign count_o  = cnt_q;
    assign bypass   = Pass && empty_o && wvalid_i;
    assign rvalid_o = ~empty_o | bypass;
    assign rdata_o  = bypass ? wdata_i : mem_q[rptr_q];
    assign pop      = ~empty_o & rready_i;
    // A bypassed word consumed in the same cycle is never stored.
    assign push     = wvalid_i & ~full_o & ~(bypass & rready_i);

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    end

    // Control state; cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tlul_sram_responder.sv
// TL-UL device-side responder driving an SRAM-style req/gnt/rvalid port.
// Replies are returned strictly in request order; malformed requests are
// answered with d_error without touching memory.
module tlul_sram_responder
    import tlul_pkg::*, tlul_sram_responder_pkg::*;
#(
    parameter int Outstanding = 2,
    parameter int AddrWidth   = 32,
    parameter bit ErrOnRead   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tl_h2d_t              tl_i,
    output tl_d2h_t              tl_o,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [31:0]          wdata_o,
    output logic [31:0]          wmask_o,
    input  logic                 rvalid_i,
    input  logic [31:0]          rdata_i,
    input  logic                 rerror_i
);
    localparam int PendW = $clog2(Outstanding + 1);

    logic             req_err, a_ready, accept, grant, full;
    logic [3:0]       lanes;
    meta_t            meta_in, head;
    logic [MetaW-1:0] meta_rdata;
    logic             meta_vld, meta_full, meta_empty;
    logic [PendW-1:0] meta_cnt;
    logic [RspW-1:0]  rsp_rdata;
    logic             rsp_vld, rsp_full, rsp_empty, rsp_push;
    logic [PendW-1:0] rsp_cnt;
    logic [PendW-1:0] pend_q, pend_d;
    logic             d_valid, d_fire;
    logic             unused_sigs;

    // Legality checks on the A-channel request.
    always_comb begin
        req_err = 1'b0;
        lanes   = lane_mask(tl_i.a_address[1:0], tl_i.a_size);
        if (!(tl_i.a_opcode inside {Get, PutFullData, PutPartialData})) req_err = 1'b1;
        if (tl_i.a_size > 2'd2) req_err = 1'b1;
        if (tl_i.a_size == 2'd1 && tl_i.a_address[0]) req_err = 1'b1;
        if (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] != 2'b00) req_err = 1'b1;
        if ((tl_i.a_mask & ~lanes) != 4'b0000) req_err = 1'b1;
        if (tl_i.a_opcode == PutFullData && tl_i.a_mask != lanes) req_err = 1'b1;
        if (tl_i.a_opcode == Get && ErrOnRead) req_err = 1'b1;
    end

    // full uses the registered occupancy, so a pop this cycle does not free a slot yet.
    assign full    = meta_full;
    assign req_o   = tl_i.a_valid & ~req_err & ~full & ~rst_i;
    assign a_ready = ~full & (req_err | gnt_i) & ~rst_i;
    assign accept  = tl_i.a_valid & a_ready;
    assign grant   = req_o & gnt_i;

    assign we_o    = (tl_i.a_opcode != Get);
    assign addr_o  = AddrWidth'(tl_i.a_address[31:2]);
    assign wdata_o = tl_i.a_data;
    assign wmask_o = expand_mask(tl_i.a_mask);

    assign meta_in = '{opcode: tl_i.a_opcode, size: tl_i.a_size,
                       source: tl_i.a_source, req_err: req_err};

    // Stray rvalid pulses (e.g. from before a reset) are dropped when nothing is pending.
    assign rsp_push = rvalid_i & (pend_q != '0);

    // Count of granted memory requests still waiting for rvalid.
    always_comb begin
        pend_d = pend_q + PendW'(grant) - PendW'(rsp_push);
    end

    // Pending-memory counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    tlul_fifo_sync #(.Width(MetaW), .Depth(Outstanding), .Pass(1'b0)) u_meta_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (accept),
        .wdata_i  (meta_in),
        .rvalid_o (meta_vld),
        .rready_i (d_fire),
        .rdata_o  (meta_rdata),
        .count_o  (meta_cnt),
        .full_o   (meta_full),
        .empty_o  (meta_empty)
    );

    tlul_fifo_sync #(.Width(RspW), .Depth(Outstanding), .Pass(1'b1)) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (rsp_push),
        .wdata_i  ({rdata_i, rerror_i}),
        .rvalid_o (rsp_vld),
        .rready_i (d_fire & ~head.req_err),
        .rdata_o  (rsp_rdata),
        .count_o  (rsp_cnt),
        .full_o   (rsp_full),
        .empty_o  (rsp_empty)
    );

    assign head    = meta_t'(meta_rdata);
    assign d_valid = meta_vld & (head.req_err | rsp_vld) & ~rst_i;
    assign d_fire  = d_valid & tl_i.d_ready;

    // D-channel response built from the head entry and its memory reply.
    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = (head.opcode == Get) ? AccessAckData : AccessAck;
        tl_o.d_size   = head.size;
        tl_o.d_source = head.source;
        tl_o.d_data   = (head.opcode == Get && !head.req_err) ? rsp_rdata[32:1] : 32'h0;
        tl_o.d_error  = head.req_err | (rsp_vld & rsp_rdata[0]);
    end

    assign unused_sigs = ^{tl_i.a_param, meta_cnt, meta_empty, rsp_cnt, rsp_full, rsp_empty};

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Directed bench for tlul_sram_responder with a small in-order memory model.
module tb_tlul_sram_responder;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        req_o, gnt_i, we_o, rvalid_i, rerror_i;
    logic [31:0] addr_o, wdata_o, wmask_o, rdata_i;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_delay = 1;

    tlul_sram_responder dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .tl_i     (tl_i),
        .tl_o     (tl_o),
        .req_o    (req_o),
        .gnt_i    (gnt_i),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .wmask_o  (wmask_o),
        .rvalid_i (rvalid_i),
        .rdata_i  (rdata_i),
        .rerror_i (rerror_i)
    );

    always #5 clk = ~clk;

    // Memory model: grants are sampled mid-cycle, replies are issued in order
    // mem_delay cycles after the grant; word 0xFF reports a memory error.
    logic [31:0] mem [256];
    logic        g_seen = 1'b0;
    logic        g_we;
    logic [31:0] g_addr, g_wdata, g_wmask;
    int          edge_n = 0;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic        err_q[$];

    always @(negedge clk) begin
        g_seen  = req_o & gnt_i;
        g_we    = we_o;
        g_addr  = addr_o;
        g_wdata = wdata_o;
        g_wmask = wmask_o;
    end

    always @(posedge clk) begin
        edge_n++;
        if (g_seen === 1'b1) begin
            if (g_we) mem[g_addr[7:0]] = (mem[g_addr[7:0]] & ~g_wmask) | (g_wdata & g_wmask);
            due_q.push_back(edge_n + mem_delay - 1);
            dat_q.push_back(mem[g_addr[7:0]]);
            err_q.push_back(g_addr[7:0] == 8'hFF);
        end
        #1;
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        rerror_i = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= edge_n) begin
            rvalid_i = 1'b1;
            rdata_i  = dat_q.pop_front();
            rerror_i = err_q.pop_front();
            void'(due_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(op);
        tl_i.a_param   = 3'h0;
        tl_i.a_address = addr;
        tl_i.a_size    = size;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
    endtask

    task automatic clr_a();
        tl_i.a_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_ready: got %b want 0", tl_o.a_ready); end
        n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", req_o); end
        n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_d_valid: got %b want 0", tl_o.d_valid); end
        tick();
        rst_i = 1'b0;
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_a_ready: got %b want 1", tl_o.a_ready); end
        n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_d_valid: got %b want 0", tl_o.d_valid); end
        tick();
    endtask

    task automatic test_get();
        mem[8'h40] = 32'hDEADBEEF;
        mem_delay = 1;
        set_a(Get, 32'h100, 2'd2, 4'hF, 32'h0, 8'd5);
        gnt_i = 1'b0;
        smp();
        n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL get_nognt_req: got %b want 1", req_o); end
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_bad++; $display("FAIL get_nognt_a_ready: got %b want 0", tl_o.a_ready); end
        tick();
        gnt_i = 1'b1;
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL get_a_ready: got %b want 1", tl_o.a_ready); end
        n_cmp++; if (we_o !== 1'b0) begin n_bad++; $display("FAIL get_we: got %b want 0", we_o); end
        n_cmp++; if (addr_o !== 32'h40) begin n_bad++; $display("FAIL get_addr: got %h want 00000040", addr_o); end
        tick();
        clr_a();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL get_d_valid: got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_opcode !== AccessAckData) begin n_bad++; $display("FAIL get_d_opcode: got %0d want 1", tl_o.d_opcode); end
        n_cmp++; if (tl_o.d_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL get_d_data: got %h want deadbeef", tl_o.d_data); end
        n_cmp++; if (tl_o.d_error !== 1'b0) begin n_bad++; $display("FAIL get_d_error: got %b want 0", tl_o.d_error); end
        n_cmp++; if (tl_o.d_source !== 8'd5) begin n_bad++; $display("FAIL get_d_source: got %0d want 5", tl_o.d_source); end
        n_cmp++; if (tl_o.d_size !== 2'd2) begin n_bad++; $display("FAIL get_d_size: got %0d want 2", tl_o.d_size); end
        tick();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL get_d_valid_after: got %b want 0", tl_o.d_valid); end
        tick();
    endtask

    task automatic test_put_partial();
        set_a(PutPartialData, 32'h202, 2'd1, 4'b1100, 32'hABCD0000, 8'd7);
        smp();
        n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL put_req: got %b want 1", req_o); end
        n_cmp++; if (we_o !== 1'b1) begin n_bad++; $display("FAIL put_we: got %b want 1", we_o); end
        n_cmp++; if (addr_o !== 32'h80) begin n_bad++; $display("FAIL put_addr: got %h want 00000080", addr_o); end
        n_cmp++; if (wmask_o !== 32'hFFFF0000) begin n_bad++; $display("FAIL put_wmask: got %h want ffff0000", wmask_o); end
        n_cmp++; if (wdata_o !== 32'hABCD0000) begin n_bad++; $display("FAIL put_wdata: got %h want abcd0000", wdata_o); end
        tick();
        clr_a();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL put_d_valid: got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_opcode !== AccessAck) begin n_bad++; $display("FAIL put_d_opcode: got %0d want 0", tl_o.d_opcode); end
        n_cmp++; if (tl_o.d_error !== 1'b0) begin n_bad++; $display("FAIL put_d_error: got %b want 0", tl_o.d_error); end
        n_cmp++; if (tl_o.d_source !== 8'd7) begin n_bad++; $display("FAIL put_d_source: got %0d want 7", tl_o.d_source); end
        n_cmp++; if (tl_o.d_data !== 32'h0) begin n_bad++; $display("FAIL put_d_data: got %h want 0", tl_o.d_data); end
        tick();
    endtask

    task automatic test_req_checks();
        logic [2:0]  ops   [5] = '{3'd4, 3'd7, 3'd4, 3'd4, 3'd0};
        logic [31:0] addrs [5] = '{32'h101, 32'h100, 32'h100, 32'h100, 32'h100};
        logic [1:0]  sizes [5] = '{2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0]  masks [5] = '{4'hF, 4'hF, 4'hF, 4'b0010, 4'b0001};
        logic [2:0]  dops  [5] = '{3'd1, 3'd0, 3'd1, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            set_a(ops[i], addrs[i], sizes[i], masks[i], 32'h0, 8'(9 + i));
            smp();
            n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL err%0d_req: got %b want 0", i, req_o); end
            n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL err%0d_a_ready: got %b want 1", i, tl_o.a_ready); end
            n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL err%0d_d_valid_early: got %b want 0", i, tl_o.d_valid); end
            tick();
            clr_a();
            smp();
            n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL err%0d_d_valid: got %b want 1", i, tl_o.d_valid); end
            n_cmp++; if (tl_o.d_error !== 1'b1) begin n_bad++; $display("FAIL err%0d_d_error: got %b want 1", i, tl_o.d_error); end
            n_cmp++; if (tl_o.d_source !== 8'(9 + i)) begin n_bad++; $display("FAIL err%0d_d_source: got %0d want %0d", i, tl_o.d_source, 9 + i); end
            n_cmp++; if (tl_o.d_opcode !== tl_d_op_e'(dops[i])) begin n_bad++; $display("FAIL err%0d_d_opcode: got %0d want %0d", i, tl_o.d_opcode, dops[i]); end
            n_cmp++; if (tl_o.d_data !== 32'h0) begin n_bad++; $display("FAIL err%0d_d_data: got %h want 0", i, tl_o.d_data); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        mem[8'h10] = 32'h11;
        mem[8'h11] = 32'h22;
        mem[8'h12] = 32'h33;
        mem_delay = 1;
        tl_i.d_ready = 1'b0;
        set_a(Get, 32'h40, 2'd2, 4'hF, 32'h0, 8'd1);
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_a_ready1: got %b want 1", tl_o.a_ready); end
        tick();
        set_a(Get, 32'h44, 2'd2, 4'hF, 32'h0, 8'd2);
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_a_ready2: got %b want 1", tl_o.a_ready); end
        tick();
        set_a(Get, 32'h48, 2'd2, 4'hF, 32'h0, 8'd3);
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_a_ready3: got %b want 0", tl_o.a_ready); end
        n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL b2b_req_full: got %b want 0", req_o); end
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_d_valid: got %b want 1", tl_o.d_valid); end
        tick();
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_a_ready_stall: got %b want 0", tl_o.a_ready); end
        n_cmp++; if (tl_o.d_source !== 8'd1) begin n_bad++; $display("FAIL b2b_stall_source: got %0d want 1", tl_o.d_source); end
        tick();
        tl_i.d_ready = 1'b1;
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_a_ready_poppush: got %b want 0", tl_o.a_ready); end
        n_cmp++; if (tl_o.d_source !== 8'd1) begin n_bad++; $display("FAIL b2b_src1: got %0d want 1", tl_o.d_source); end
        n_cmp++; if (tl_o.d_data !== 32'h11) begin n_bad++; $display("FAIL b2b_data1: got %h want 11", tl_o.d_data); end
        tick();
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_a_ready_freed: got %b want 1", tl_o.a_ready); end
        n_cmp++; if (tl_o.d_source !== 8'd2) begin n_bad++; $display("FAIL b2b_src2: got %0d want 2", tl_o.d_source); end
        n_cmp++; if (tl_o.d_data !== 32'h22) begin n_bad++; $display("FAIL b2b_data2: got %h want 22", tl_o.d_data); end
        tick();
        clr_a();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_d_valid3: got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_source !== 8'd3) begin n_bad++; $display("FAIL b2b_src3: got %0d want 3", tl_o.d_source); end
        n_cmp++; if (tl_o.d_data !== 32'h33) begin n_bad++; $display("FAIL b2b_data3: got %h want 33", tl_o.d_data); end
        tick();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", tl_o.d_valid); end
        tick();
    endtask

    task automatic test_ordering();
        mem_delay = 4;
        set_a(Get, 32'h100, 2'd2, 4'hF, 32'h0, 8'd4);
        tick();
        set_a(3'd7, 32'h100, 2'd2, 4'hF, 32'h0, 8'd6);
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL ord_err_accept: got %b want 1", tl_o.a_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL ord_wait%0d: got %b want 0", i, tl_o.d_valid); end
            tick();
            clr_a();
            smp();
        end
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL ord_get_valid: got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_source !== 8'd4) begin n_bad++; $display("FAIL ord_get_src: got %0d want 4", tl_o.d_source); end
        n_cmp++; if (tl_o.d_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ord_get_data: got %h want deadbeef", tl_o.d_data); end
        n_cmp++; if (tl_o.d_error !== 1'b0) begin n_bad++; $display("FAIL ord_get_err: got %b want 0", tl_o.d_error); end
        tick();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL ord_err_valid: got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_source !== 8'd6) begin n_bad++; $display("FAIL ord_err_src: got %0d want 6", tl_o.d_source); end
        n_cmp++; if (tl_o.d_error !== 1'b1) begin n_bad++; $display("FAIL ord_err_err: got %b want 1", tl_o.d_error); end
        n_cmp++; if (tl_o.d_opcode !== AccessAck) begin n_bad++; $display("FAIL ord_err_opcode: got %0d want 0", tl_o.d_opcode); end
        tick();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL ord_drained: got %b want 0", tl_o.d_valid); end
        tick();
        mem_delay = 1;
    endtask

    task automatic test_rerror();
        mem_delay = 1;
        set_a(Get, 32'h3FC, 2'd2, 4'hF, 32'h0, 8'd8);
        tick();
        clr_a();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL rerr_d_valid: got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_error !== 1'b1) begin n_bad++; $display("FAIL rerr_d_error: got %b want 1", tl_o.d_error); end
        n_cmp++; if (tl_o.d_source !== 8'd8) begin n_bad++; $display("FAIL rerr_d_source: got %0d want 8", tl_o.d_source); end
        tick();
    endtask

    task automatic test_reset_mid();
        mem_delay = 3;
        tl_i.d_ready = 1'b0;
        set_a(Get, 32'h100, 2'd2, 4'hF, 32'h0, 8'd1);
        tick();
        set_a(Get, 32'h104, 2'd2, 4'hF, 32'h0, 8'd2);
        tick();
        clr_a();
        rst_i = 1'b1;
        smp();
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_a_ready: got %b want 0", tl_o.a_ready); end
        tick();
        rst_i = 1'b0;
        tl_i.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL mid_late_d_valid%0d: got %b want 0", i, tl_o.d_valid); end
            n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL mid_a_ready%0d: got %b want 1", i, tl_o.a_ready); end
            tick();
        end
        mem_delay = 1;
        set_a(Get, 32'h100, 2'd2, 4'hF, 32'h0, 8'd3);
        smp();
        n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL mid_new_req: got %b want 1", req_o); end
        tick();
        clr_a();
        smp();
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL mid_new_d_valid: got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_source !== 8'd3) begin n_bad++; $display("FAIL mid_new_src: got %0d want 3", tl_o.d_source); end
        n_cmp++; if (tl_o.d_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mid_new_data: got %h want deadbeef", tl_o.d_data); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_i        = 1'b1;
        tl_i         = '0;
        tl_i.d_ready = 1'b1;
        gnt_i        = 1'b1;
        rvalid_i     = 1'b0;
        rdata_i      = 32'h0;
        rerror_i     = 1'b0;
        test_reset();
        test_get();
        test_put_partial();
        test_req_checks();
        test_back_to_back();
        test_ordering();
        test_rerror();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
